// File: rtl/dp_pkg.sv
// Shared helpers for the dot-product datapath: width derivation and saturation bounds.
package dp_pkg;

  localparam int SAT_MAXW = 128;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int tree_w(input int dw, input int num);
    return 2 * dw + clog2(num);
  endfunction

  // Bounds of a w-bit signed range, returned in the low w bits of a wide word.
  function automatic logic [SAT_MAXW-1:0] sat_max(input int w);
    return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
  endfunction

  function automatic logic [SAT_MAXW-1:0] sat_min(input int w);
    return SAT_MAXW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/dp_adder_tree.sv
// Registered signed reduction tree: one register level per halving, valid/last
// sideband travelling alongside, all levels gated by a shared clock enable.
module dp_adder_tree
  import dp_pkg::*;
#(
  parameter int NUM  = 16,
  parameter int IN_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ce,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic [NUM*IN_W-1:0]             in_data,
  output logic                            out_valid,
  output logic                            out_last,
  output logic signed [IN_W+clog2(NUM)-1:0] out_data
);

  localparam int L = clog2(NUM);

  // Level 0 is the unregistered input view; level lv holds NUM>>lv sums of IN_W+lv bits.
  for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
    logic signed [IN_W+lv-1:0] sum [NUM>>lv];
    logic                      vld;
    logic                      lst;

    if (lv == 0) begin : g_in
      always_comb begin
        sum = '{default: '0};
        for (int unsigned i = 0; i < NUM; i++) sum[i] = in_data[i*IN_W +: IN_W];
        vld = in_valid;
        lst = in_last;
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld <= 1'b0;
          lst <= 1'b0;
          for (int unsigned i = 0; i < (NUM >> lv); i++) sum[i] <= '0;
        end else if (ce) begin
          vld <= g_lvl[lv-1].vld;
          lst <= g_lvl[lv-1].lst;
          for (int unsigned i = 0; i < (NUM >> lv); i++)
            sum[i] <= (IN_W+lv)'(g_lvl[lv-1].sum[2*i]) + (IN_W+lv)'(g_lvl[lv-1].sum[2*i+1]);
        end
      end
    end
  end

  assign out_valid = g_lvl[L].vld;
  assign out_last  = g_lvl[L].lst;
  assign out_data  = g_lvl[L].sum[0];

endmodule

// File: rtl/dot_product_acc.sv
// Multi-beat signed dot-product accumulator: multiply stage, registered adder tree,
// accumulate/output stage. Define DOT_PRODUCT_ACC_SATURATE_EN for a saturating accumulate.
module dot_product_acc
  import dp_pkg::*;
#(
  parameter int NUM   = 16,
  parameter int DW    = 16,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DW*NUM-1:0]       s_a,
  input  logic [DW*NUM-1:0]       s_b,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [ACC_W-1:0] m_data,
  output logic [CNT_W-1:0]        m_beats
);

  localparam int PROD_W = prod_w(DW);
  localparam int TREE_W = tree_w(DW, NUM);

  logic run;
  logic ce;

  // run keeps s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign ce      = run && (!m_valid || m_ready);
  assign s_ready = ce;

  logic [NUM*PROD_W-1:0] prod_c;
  logic [NUM*PROD_W-1:0] prod;
  logic                  prod_vld;
  logic                  prod_lst;

  always_comb begin
    prod_c = '0;
    for (int unsigned i = 0; i < NUM; i++)
      prod_c[i*PROD_W +: PROD_W] = PROD_W'($signed(s_a[i*DW +: DW])) *
                                   PROD_W'($signed(s_b[i*DW +: DW]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      prod_lst <= 1'b0;
    end else if (ce) begin
      prod     <= prod_c;
      prod_vld <= s_valid;
      prod_lst <= s_valid && s_last;
    end
  end

  logic                     tree_vld;
  logic                     tree_lst;
  logic signed [TREE_W-1:0] tree_sum;

  dp_adder_tree #(
    .NUM  (NUM),
    .IN_W (PROD_W)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (prod_vld),
    .in_last   (prod_lst),
    .in_data   (prod),
    .out_valid (tree_vld),
    .out_last  (tree_lst),
    .out_data  (tree_sum)
  );

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    first;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0]        cnt_c;

`ifdef DOT_PRODUCT_ACC_SATURATE_EN
  localparam logic [SAT_MAXW-1:0] MAX_FULL = sat_max(ACC_W);
  localparam logic [SAT_MAXW-1:0] MIN_FULL = sat_min(ACC_W);
  localparam logic [ACC_W-1:0]    ACC_MAX  = MAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0]    ACC_MIN  = MIN_FULL[ACC_W-1:0];
  logic signed [ACC_W:0] wide;
`endif

  always_comb begin
    ext   = ACC_W'(tree_sum);
    base  = first ? '0 : acc;
    cnt_c = first ? CNT_W'(1) : cnt + CNT_W'(1);
`ifdef DOT_PRODUCT_ACC_SATURATE_EN
    // One guard bit: disagreement with the ACC_W sign bit means overflow.
    wide = (ACC_W+1)'(ext) + (ACC_W+1)'(base);
    if (wide[ACC_W] != wide[ACC_W-1]) sum_c = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else                              sum_c = wide[ACC_W-1:0];
`else
    sum_c = ext + base;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      first   <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_beats <= '0;
    end else if (ce) begin
      if (tree_vld && tree_lst) begin
        m_valid <= 1'b1;
        m_data  <= sum_c;
        m_beats <= cnt_c;
        acc     <= '0;
        cnt     <= cnt_c;
        first   <= 1'b1;
      end else begin
        m_valid <= 1'b0;
        if (tree_vld) begin
          acc   <= sum_c;
          cnt   <= cnt_c;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_acc.sv
// Directed self-checking bench for dot_product_acc (default 16-lane build plus a
// 2-lane ACC_W=33 instance for the wrap/saturate boundary).
module tb_dot_product_acc;

  logic clk;
  logic rst_n;

  logic               s_valid, s_ready, s_last, m_valid, m_ready;
  logic [255:0]       s_a, s_b;
  logic signed [47:0] m_data;
  logic [15:0]        m_beats;
  logic signed [15:0] a_l [16];
  logic signed [15:0] b_l [16];

  logic               sm_s_valid, sm_s_ready, sm_s_last, sm_m_valid, sm_m_ready;
  logic [31:0]        sm_s_a, sm_s_b;
  logic signed [32:0] sm_m_data;
  logic [15:0]        sm_m_beats;

  int checks;
  int failures;

  dot_product_acc #(.NUM(16), .DW(16), .ACC_W(48), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_beats(m_beats)
  );

  dot_product_acc #(.NUM(2), .DW(16), .ACC_W(33), .CNT_W(16)) u_small (
    .clk(clk), .rst_n(rst_n),
    .s_valid(sm_s_valid), .s_ready(sm_s_ready), .s_a(sm_s_a), .s_b(sm_s_b), .s_last(sm_s_last),
    .m_valid(sm_m_valid), .m_ready(sm_m_ready), .m_data(sm_m_data), .m_beats(sm_m_beats)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    s_a = '0;
    s_b = '0;
    for (int i = 0; i < 16; i++) begin
      s_a[i*16 +: 16] = a_l[i];
      s_b[i*16 +: 16] = b_l[i];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [15:0] a, input logic signed [15:0] b);
    for (int i = 0; i < 16; i++) begin
      a_l[i] = a;
      b_l[i] = b;
    end
  endtask

  task automatic set_lane0(input logic signed [15:0] a, input logic signed [15:0] b);
    set_all(16'sd0, 16'sd0);
    a_l[0] = a;
    b_l[0] = b;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input logic last);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_last  = last;
    for (int k = 0; k < 100 && !done; k++) begin
      done = s_ready;
      step();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_accept: s_ready never seen, required 1");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_result(output int n, output bit ok);
    n = 0;
    while (!m_valid && n < 60) begin
      step();
      n++;
    end
    ok = m_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks += 4;
    if (m_valid !== 1'b0)  begin failures++; $display("FAIL reset_m_valid: got %b required 0", m_valid); end
    if (m_data !== 48'sd0) begin failures++; $display("FAIL reset_m_data: got %0d required 0", m_data); end
    if (m_beats !== 16'd0) begin failures++; $display("FAIL reset_m_beats: got %0d required 0", m_beats); end
    if (s_ready !== 1'b0)  begin failures++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
    rst_n = 1'b1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge: got %b required 0", s_ready); end
    step();
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge: got %b required 1", s_ready); end
  endtask

  task automatic test_single_latency();
    int n;
    bit ok;
    set_all(16'sd2, 16'sd3);
    send(1'b1);
    wait_result(n, ok);
    // The accepting cycle counts as cycle 1; L=4 tree levels + M + A stages -> 6.
    checks += 4;
    if (!ok || (n + 1) != 6) begin failures++; $display("FAIL single_latency: got %0d cycles (valid=%b) required 6", n + 1, ok); end
    if (m_data !== 48'sd96)  begin failures++; $display("FAIL single_data: got %0d required 96", m_data); end
    if (m_beats !== 16'd1)   begin failures++; $display("FAIL single_beats: got %0d required 1", m_beats); end
    step();
    if (m_valid !== 1'b0)    begin failures++; $display("FAIL single_drop: m_valid got %b required 0", m_valid); end
  endtask

  task automatic test_multi_beat();
    int n;
    bit ok;
    set_lane0(16'sd1, 16'sd1);
    send(1'b0);
    send(1'b0);
    send(1'b1);
    wait_result(n, ok);
    checks += 2;
    if (!ok || m_data !== 48'sd3) begin failures++; $display("FAIL multi_data: got %0d (valid=%b) required 3", m_data, ok); end
    if (m_beats !== 16'd3)        begin failures++; $display("FAIL multi_beats: got %0d required 3", m_beats); end
    step();
    for (int b = 0; b < 3; b++) begin
      send(b == 2);
      step();
      step();
    end
    wait_result(n, ok);
    checks += 2;
    if (!ok || m_data !== 48'sd3) begin failures++; $display("FAIL gap_data: got %0d (valid=%b) required 3", m_data, ok); end
    if (m_beats !== 16'd3)        begin failures++; $display("FAIL gap_beats: got %0d required 3", m_beats); end
    step();
  endtask

  task automatic test_negative();
    int n;
    bit ok;
    logic signed [47:0] big;
    big = 48'sh4_0000_0000;
    set_all(-16'sd4, 16'sd5);
    send(1'b1);
    wait_result(n, ok);
    checks += 2;
    if (!ok || m_data !== -48'sd320) begin failures++; $display("FAIL neg_data: got %0d (valid=%b) required -320", m_data, ok); end
    if (m_beats !== 16'd1)           begin failures++; $display("FAIL neg_beats: got %0d required 1", m_beats); end
    step();
    set_all(16'sh8000, 16'sh8000);
    send(1'b1);
    wait_result(n, ok);
    checks++;
    if (!ok || m_data !== big) begin failures++; $display("FAIL minmin_data: got %0d (valid=%b) required %0d", m_data, ok, big); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    int extra;
    bit ok;
    m_ready = 1'b0;
    set_all(16'sd1, 16'sd1);
    send(1'b1);
    set_all(16'sd2, 16'sd1);
    send(1'b1);
    wait_result(n, ok);
    checks += 2;
    if (!ok || m_data !== 48'sd16) begin failures++; $display("FAIL bp_first: got %0d (valid=%b) required 16", m_data, ok); end
    if (s_ready !== 1'b0)          begin failures++; $display("FAIL bp_ready: got %b required 0", s_ready); end
    step();
    step();
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 48'sd16 || m_beats !== 16'd1) begin
      failures++;
      $display("FAIL bp_hold: got valid=%b data=%0d beats=%0d required 1/16/1", m_valid, m_data, m_beats);
    end
    m_ready = 1'b1;
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 48'sd32) begin
      failures++;
      $display("FAIL bp_second: got valid=%b data=%0d required 1/32", m_valid, m_data);
    end
    step();
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_valid) extra++;
      step();
    end
    checks++;
    if (extra != 0) begin failures++; $display("FAIL bp_dup: got %0d extra results required 0", extra); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    set_lane0(16'sd5, 16'sd1);
    send(1'b0);
    send(1'b0);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (m_valid !== 1'b0 || m_beats !== 16'd0) begin failures++; $display("FAIL midrst_ctl: got valid=%b beats=%0d required 0/0", m_valid, m_beats); end
    if (m_data !== 48'sd0) begin failures++; $display("FAIL midrst_data: got %0d required 0", m_data); end
    step();
    step();
    rst_n = 1'b1;
    step();
    set_lane0(16'sd7, 16'sd1);
    send(1'b0);
    send(1'b1);
    wait_result(n, ok);
    checks += 2;
    if (!ok || m_data !== 48'sd14) begin failures++; $display("FAIL postrst_data: got %0d (valid=%b) required 14", m_data, ok); end
    if (m_beats !== 16'd2)         begin failures++; $display("FAIL postrst_beats: got %0d required 2", m_beats); end
    step();
  endtask

  task automatic test_saturate();
    logic signed [32:0] expv;
    bit done;
    int n;
`ifdef DOT_PRODUCT_ACC_SATURATE_EN
    expv = 33'sh0_FFFF_FFFF;
`else
    expv = 33'sh1_0000_0000;
`endif
    sm_s_a = {16'h8000, 16'h8000};
    sm_s_b = {16'h8000, 16'h8000};
    for (int b = 0; b < 2; b++) begin
      done       = 1'b0;
      sm_s_valid = 1'b1;
      sm_s_last  = (b == 1);
      for (int k = 0; k < 100 && !done; k++) begin
        done = sm_s_ready;
        step();
      end
      checks++;
      if (!done) begin failures++; $display("FAIL sat_accept: beat %0d not accepted", b); end
    end
    sm_s_valid = 1'b0;
    sm_s_last  = 1'b0;
    n = 0;
    while (!sm_m_valid && n < 60) begin
      step();
      n++;
    end
    checks += 2;
    if (!sm_m_valid || sm_m_data !== expv) begin failures++; $display("FAIL sat_data: got %0d (valid=%b) required %0d", sm_m_data, sm_m_valid, expv); end
    if (sm_m_beats !== 16'd2) begin failures++; $display("FAIL sat_beats: got %0d required 2", sm_m_beats); end
    step();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    m_ready    = 1'b1;
    sm_s_valid = 1'b0;
    sm_s_last  = 1'b0;
    sm_s_a     = '0;
    sm_s_b     = '0;
    sm_m_ready = 1'b1;
    set_all(16'sd0, 16'sd0);
    test_reset();
    test_single_latency();
    test_multi_beat();
    test_negative();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
